// File: rtl/mul_hilo_unit.sv
// mul_hilo_unit: iterative shift-add multiplier / multiply-accumulate unit
// that executes MULT, MULTU, MUL, MADD and MSUB and owns the HI/LO registers.
// Operands are reduced to magnitudes and the product sign is applied in the
// one-cycle FIXUP step, so the CALC loop is a plain unsigned shift-add.
// Optional feature macro: HILO_WRITE_EN adds HiWe/LoWe (mthi/mtlo) write ports.
module mul_hilo_unit #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [4:0]       ALUControl,
`ifdef HILO_WRITE_EN
  input  logic             HiWe,
  input  logic             LoWe,
`endif
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] MulResult,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam logic [4:0] OP_MULT  = 5'b00011;
  localparam logic [4:0] OP_MULTU = 5'b00100;
  localparam logic [4:0] OP_MUL   = 5'b10011;
  localparam logic [4:0] OP_MADD  = 5'b10100;
  localparam logic [4:0] OP_MSUB  = 5'b10101;

  localparam int N     = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(N + 1);
  localparam int PW    = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [4:0]         op;
  logic               neg;
  logic               accept;
  logic               signed_op;
  logic               sign_in;

  logic [PW-1:0]      acc;
  logic [PW-1:0]      mcand;
  logic [WIDTH-1:0]   mplier;
  logic [PW-1:0]      prod;
  logic [PW-1:0]      hilo_cur;

  // Recognise the multi-cycle multiply codes; everything else belongs to the ALU.
  function automatic logic is_mul_op(input logic [4:0] code);
    return (code == OP_MULT) || (code == OP_MULTU) || (code == OP_MUL) ||
           (code == OP_MADD) || (code == OP_MSUB);
  endfunction

  // Magnitude of an operand; -2^(WIDTH-1) maps to 2^(WIDTH-1), still fits unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             is_signed);
    logic signed [WIDTH-1:0] sv;
    sv = v;
    if (is_signed && (sv < 0))
      return -v;
    else
      return v;
  endfunction

  // Sum of the multiplicand copies selected by the current multiplier bits.
  function automatic logic [PW-1:0] partial_sum(input logic [PW-1:0]             mc,
                                                input logic [BITS_PER_CYCLE-1:0] bits);
    logic [PW-1:0] s;
    s = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++)
      if (bits[i])
        s = s + (mc << i);
    return s;
  endfunction

  assign signed_op = (ALUControl != OP_MULTU);
  assign sign_in   = signed_op & (A[WIDTH-1] ^ B[WIDTH-1]);
  assign accept    = (state == IDLE) && Start && is_mul_op(ALUControl);
  assign Busy      = (state != IDLE);
  assign hilo_cur  = {Hi, Lo};

  // Signed product presented to the FIXUP write-back.
  always_comb begin
    prod = acc;
    if (neg)
      prod = -acc;
  end

  // Next-state logic: IDLE -> CALC (N cycles) -> FIXUP -> IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    if (cnt == '0) state_nxt = FIXUP;
      FIXUP:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control registers: state, iteration counter, latched opcode and sign, Done pulse.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= IDLE;
      cnt   <= '0;
      op    <= '0;
      neg   <= 1'b0;
      Done  <= 1'b0;
    end else begin
      state <= state_nxt;
      Done  <= (state == FIXUP);
      if (accept) begin
        op  <= ALUControl;
        neg <= sign_in;
        cnt <= CNT_W'(N - 1);
      end else if (state == CALC) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // Shift-add datapath: load magnitudes on accept, retire BITS_PER_CYCLE bits per CALC cycle.
  always_ff @(posedge Clk) begin
    if (accept) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, magnitude(A, signed_op)};
      mplier <= magnitude(B, signed_op);
    end else if (state == CALC) begin
      acc    <= acc + partial_sum(mcand, mplier[BITS_PER_CYCLE-1:0]);
      mcand  <= mcand << BITS_PER_CYCLE;
      mplier <= mplier >> BITS_PER_CYCLE;
    end
  end

  // Architectural HI/LO and MUL result; written in FIXUP (or by mthi/mtlo while idle).
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      Hi        <= '0;
      Lo        <= '0;
      MulResult <= '0;
    end else if (state == FIXUP) begin
      case (op)
        OP_MULT, OP_MULTU: {Hi, Lo} <= prod;
        OP_MADD:           {Hi, Lo} <= hilo_cur + prod;
        OP_MSUB:           {Hi, Lo} <= hilo_cur - prod;
        OP_MUL:            MulResult <= prod[WIDTH-1:0];
        default:           ;
      endcase
    end
`ifdef HILO_WRITE_EN
    else if (state == IDLE) begin
      if (HiWe) Hi <= A;
      if (LoWe) Lo <= A;
    end
`endif
  end

endmodule

// File: tb/tb_mul_hilo_unit.sv
// tb_mul_hilo_unit: directed-vector bench for mul_hilo_unit (WIDTH=32, BITS_PER_CYCLE=1).
// Define HILO_WRITE_EN to also exercise the mthi/mtlo write ports.
module tb_mul_hilo_unit;

  localparam logic [4:0] OP_ADD   = 5'b00000;
  localparam logic [4:0] OP_MULT  = 5'b00011;
  localparam logic [4:0] OP_MULTU = 5'b00100;
  localparam logic [4:0] OP_MUL   = 5'b10011;
  localparam logic [4:0] OP_MADD  = 5'b10100;
  localparam logic [4:0] OP_MSUB  = 5'b10101;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        Start = 1'b0;
  logic [4:0]  ALUControl = '0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
`ifdef HILO_WRITE_EN
  logic        HiWe = 1'b0;
  logic        LoWe = 1'b0;
`endif
  logic        Busy, Done;
  logic [31:0] MulResult, Hi, Lo;

  int n_cmp = 0;
  int n_err = 0;

  // Results of the last do_op call.
  int   op_edges;
  logic op_busy_ok;

  mul_hilo_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .ALUControl(ALUControl),
`ifdef HILO_WRITE_EN
    .HiWe(HiWe), .LoWe(LoWe),
`endif
    .A(A), .B(B), .Busy(Busy), .Done(Done),
    .MulResult(MulResult), .Hi(Hi), .Lo(Lo)
  );

  always #5 Clk = ~Clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one operation and wait (bounded) for Done. With now=1 the request is
  // driven in the current cycle (used for Start in the Done cycle).
  task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit now);
    if (!now) @(negedge Clk);
    Start = 1'b1; ALUControl = op; A = a; B = b;
    @(posedge Clk); #1;
    Start = 1'b0;
    op_edges   = -1;
    op_busy_ok = 1'b1;
    @(negedge Clk);
    if (!Busy || Done) op_busy_ok = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge Clk);
      @(negedge Clk);
      if (Done) begin
        op_edges = i;
        if (Busy) op_busy_ok = 1'b0;
        break;
      end
      if (!Busy) op_busy_ok = 1'b0;
    end
    if (op_edges < 0) check_val("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int dcount;
    logic bad;

    // Reset state
    #12;
    check_val("rst_busy", {63'd0, Busy}, 64'd0);
    check_val("rst_done", {63'd0, Done}, 64'd0);
    check_val("rst_hilo", {Hi, Lo}, 64'd0);
    check_val("rst_mulres", {32'd0, MulResult}, 64'd0);
    @(negedge Clk);
    Rst = 1'b1;

    // 1: MULTU max*max, latency and Busy profile
    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check_val("t1_latency", 64'(op_edges), 64'd33);
    check_val("t1_busy", {63'd0, op_busy_ok}, 64'd1);
    check_val("t1_hilo", {Hi, Lo}, 64'hFFFF_FFFE_0000_0001);
    @(negedge Clk);
    check_val("t1_done_width", {63'd0, Done}, 64'd0);

    // 2: signed MULT, including the most-negative corner
    do_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0);
    check_val("t2_neg", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    do_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0);
    check_val("t2_minmin", {Hi, Lo}, 64'h4000_0000_0000_0000);

    // 3: MULTU then back-to-back MADD with carry into Hi
    do_op(OP_MULTU, 32'd1, 32'hFFFF_FFFF, 1'b0);
    check_val("t3_multu", {Hi, Lo}, 64'h0000_0000_FFFF_FFFF);
    do_op(OP_MADD, 32'd1, 32'd1, 1'b1);
    check_val("t3_madd_lat", 64'(op_edges), 64'd33);
    check_val("t3_madd", {Hi, Lo}, 64'h0000_0001_0000_0000);

    // 4: clear, MSUB below zero, then MUL leaves Hi/Lo alone
    do_op(OP_MULTU, 32'd0, 32'd0, 1'b0);
    do_op(OP_MSUB, 32'd2, 32'd3, 1'b0);
    check_val("t4_msub", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    do_op(OP_MUL, 32'h0001_0000, 32'h0001_0003, 1'b0);
    check_val("t4_mul", {32'd0, MulResult}, 64'h0000_0000_0003_0000);
    check_val("t4_hilo_kept", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFFA);

    // 5a: non-multiply code is ignored
    @(negedge Clk);
    Start = 1'b1; ALUControl = OP_ADD; A = 32'd5; B = 32'd6;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      if (Busy || Done) bad = 1'b1;
    end
    Start = 1'b0;
    check_val("t5_add_ignored", {63'd0, bad}, 64'd0);
    check_val("t5_add_hilo", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFFA);

    // 5b: Start during CALC is ignored, exactly one Done
    @(negedge Clk);
    Start = 1'b1; ALUControl = OP_MULTU; A = 32'd5; B = 32'd6;
    dcount = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge Clk);
      if (i == 0) Start = 1'b0;
      if (i == 5) begin Start = 1'b1; ALUControl = OP_MULT; A = 32'd7; B = 32'd7; end
      if (i == 6) Start = 1'b0;
      if (Done) dcount++;
    end
    check_val("t5_one_done", 64'(dcount), 64'd1);
    check_val("t5_result", {Hi, Lo}, 64'd30);

    // 6: asynchronous reset during CALC aborts the operation
    @(negedge Clk);
    Start = 1'b1; ALUControl = OP_MULT; A = 32'd3; B = 32'd4;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (10) @(posedge Clk);
    #2;
    Rst = 1'b0;
    #1;
    check_val("t6_busy", {63'd0, Busy}, 64'd0);
    check_val("t6_hilo", {Hi, Lo}, 64'd0);
    check_val("t6_mulres", {32'd0, MulResult}, 64'd0);
    @(negedge Clk);
    Rst = 1'b1;
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (Done || Busy) dcount++;
    end
    check_val("t6_no_done", 64'(dcount), 64'd0);

`ifdef HILO_WRITE_EN
    // mthi in IDLE, then a write in the same cycle as a MADD start
    @(negedge Clk);
    HiWe = 1'b1; A = 32'h1234_5678;
    @(negedge Clk);
    HiWe = 1'b0;
    check_val("we_hi", {32'd0, Hi}, 64'h0000_0000_1234_5678);
    check_val("we_lo_kept", {32'd0, Lo}, 64'd0);
    @(negedge Clk);
    LoWe = 1'b1; Start = 1'b1; ALUControl = OP_MADD; A = 32'd2; B = 32'd3;
    @(posedge Clk); #1;
    LoWe = 1'b0; Start = 1'b0;
    for (int i = 0; i < 40; i++) @(negedge Clk);
    check_val("we_madd", {Hi, Lo}, 64'h1234_5678_0000_0008);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
